// File: rtl/uart_tx_periph.sv
// APB UART transmitter: register file, byte FIFO and 8N1 serialiser on tx.
// Define UART_PARITY_EN to add CR.PEN/CR.ODD and an optional parity bit.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_BRR = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  localparam int CRW = 3;
`else
  localparam int CRW = 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]    wptr_q, rptr_q, cnt;
  logic [CRW-1:0] cr_q;
  logic [15:0]    brr_q, div_q, bcnt_q;
  logic           ovf_q, tx_q, par_q, pen_q;
  state_t         st_q;
  logic [7:0]     sh_q, head;
  logic [2:0]     bit_q;
  logic [1:0]     sel;
  logic           acc, wr_en, full, empty, push, pop, tick, pen, odd;
  logic           unused;

  assign unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  assign acc    = PSEL & PENABLE;
  assign PREADY = acc;
  assign wr_en  = acc & PWRITE;
  assign sel    = PADDR[3:2];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign cnt   = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign push  = wr_en && (sel == 2'd2) && !full;
  assign pop   = (st_q == S_IDLE) && cr_q[0] && !empty;
  assign tick  = (bcnt_q == div_q);

`ifdef UART_PARITY_EN
  assign pen = cr_q[1];
  assign odd = cr_q[2];
`else
  assign pen = 1'b0;
  assign odd = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      cr_q   <= '0;
      brr_q  <= DEFAULT_BRR;
      ovf_q  <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) begin
        case (sel)
          2'd0: cr_q <= PWDATA[CRW-1:0];
          2'd1: if (PWDATA[3]) ovf_q <= 1'b0;
          2'd2: if (full) ovf_q <= 1'b1;
          2'd3: brr_q <= PWDATA[15:0];
        endcase
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= PWDATA[7:0];
  end

  // tx_q is loaded with the level of the state being entered, so it is glitch-free.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      st_q   <= S_IDLE;
      tx_q   <= 1'b1;
      bcnt_q <= '0;
      div_q  <= '0;
      sh_q   <= '0;
      bit_q  <= '0;
      par_q  <= 1'b0;
      pen_q  <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            sh_q   <= head;
            div_q  <= brr_q;
            bcnt_q <= '0;
            par_q  <= (^head) ^ odd;
            pen_q  <= pen;
            st_q   <= S_START;
            tx_q   <= 1'b0;
          end
        end
        default: begin
          bcnt_q <= tick ? 16'd0 : bcnt_q + 16'd1;
          if (tick) begin
            case (st_q)
              S_START: begin
                st_q  <= S_DATA;
                bit_q <= '0;
                tx_q  <= sh_q[0];
              end
              S_DATA: begin
                if (bit_q == 3'd7) begin
                  st_q <= pen_q ? S_PARITY : S_STOP;
                  tx_q <= pen_q ? par_q : 1'b1;
                end else begin
                  sh_q  <= sh_q >> 1;
                  tx_q  <= sh_q[1];
                  bit_q <= bit_q + 3'd1;
                end
              end
              S_PARITY: begin
                st_q <= S_STOP;
                tx_q <= 1'b1;
              end
              default: begin
                st_q <= S_IDLE;
                tx_q <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx = tx_q;

  always_comb begin
    PRDATA = '0;
    if (acc && !PWRITE) begin
      case (sel)
        2'd0: PRDATA[CRW-1:0] = cr_q;
        2'd1: begin
          PRDATA[0]        = full;
          PRDATA[1]        = empty;
          PRDATA[2]        = (st_q != S_IDLE);
          PRDATA[3]        = ovf_q;
          PRDATA[8 +: AW+1] = cnt;
        end
        2'd3: PRDATA[15:0] = brr_q;
        default: PRDATA = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: registers, FIFO overflow, frame timing,
// mid-frame reset, mid-frame BRR/EN changes and (with UART_PARITY_EN) parity.
module tb_uart_tx_periph;
  logic        PCLK = 1'b0, PRESET = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, tx;
  int tests = 0, fails = 0, cyc = 0;

  uart_tx_periph #(.FIFO_DEPTH(8), .DEFAULT_BRR(16'd867)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .tx(tx)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {28'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {28'h0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    tests++;
    if (d !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, d, exp);
    end
  endtask

  function automatic logic [10:0] mkpat(input logic [7:0] b, input logic pe, input logic od);
    logic [10:0] p;
    p = 11'h7FF;
    p[0] = 1'b0;
    p[8:1] = b;
    if (pe) p[9] = (^b) ^ od;
    return p;
  endfunction

  // Waits for the start bit, then checks every cycle of every bit.
  task automatic check_frame(input string nm, input logic [10:0] pat, input int n,
                             input int div, output int t0);
    bit ok = 0;
    t0 = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge PCLK); #1;
      if (tx === 1'b0) begin ok = 1; t0 = cyc; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s start: tx never went low within 400 cycles", nm);
      return;
    end
    for (int b = 0; b < n; b++) begin
      bit bad = 0;
      logic got = 1'b1;
      for (int c = 0; c <= div; c++) begin
        if (b != 0 || c != 0) begin @(posedge PCLK); #1; end
        if (tx !== pat[b]) begin bad = 1; got = tx; end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s bit%0d: got %b expected %b", nm, b, got, pat[b]);
      end
    end
  endtask

  task automatic check_idle(input string nm, input int ncyc);
    bit bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge PCLK); #1;
      if (tx !== 1'b1) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL %s: tx got 0 expected 1 while idle", nm); end
  endtask

  task automatic test_reset();
    bit bad = 0;
    PRESET = 1'b0;
    repeat (3) begin
      @(posedge PCLK); #1;
      if (tx !== 1'b1 || PREADY !== 1'b0 || PRDATA !== 32'h0) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL reset_outputs: tx=%b PREADY=%b PRDATA=%08h expected 1/0/0", tx, PREADY, PRDATA); end
    PRESET = 1'b1;
    chk_reg("reset_cr", 4'h0, 32'h0);
    chk_reg("reset_sr", 4'h4, 32'h2);
    chk_reg("reset_tdr", 4'h8, 32'h0);
    chk_reg("reset_brr", 4'hC, 32'd867);
    check_idle("reset_tx_idle", 20);
  endtask

  task automatic test_frame();
    int t0;
    logic [31:0] d;
    apb_write(4'hC, 32'd3);
    apb_write(4'h0, 32'h1);
    fork
      check_frame("frame55", mkpat(8'h55, 1'b0, 1'b0), 10, 3, t0);
      begin
        apb_write(4'h8, 32'h55);
        repeat (10) @(posedge PCLK);
        apb_read(4'h4, d);
        tests++;
        if (d !== 32'h6) begin fails++; $display("FAIL busy_sr: got %08h expected 00000006", d); end
      end
    join
    chk_reg("sr_after_frame", 4'h4, 32'h2);
  endtask

  task automatic test_overflow();
    int t [8];
    apb_write(4'h0, 32'h0);
    for (int i = 1; i <= 9; i++) apb_write(4'h8, i);
    chk_reg("sr_full_ovf", 4'h4, 32'h0809);
    apb_write(4'h4, 32'h8);
    chk_reg("sr_ovf_clear", 4'h4, 32'h0801);
    apb_write(4'h0, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("fifo%0d", i + 1), mkpat(8'(i + 1), 1'b0, 1'b0), 10, 3, t[i]);
      if (i > 0) begin
        tests++;
        if (t[i] - t[i-1] !== 41) begin
          fails++;
          $display("FAIL b2b_gap%0d: got %0d expected 41", i, t[i] - t[i-1]);
        end
      end
    end
    chk_reg("sr_drained", 4'h4, 32'h2);
  endtask

  task automatic test_brr_zero();
    int t0, t1;
    apb_write(4'h0, 32'h0);
    apb_write(4'hC, 32'd0);
    apb_write(4'h8, 32'h96);
    apb_write(4'h8, 32'h3B);
    apb_write(4'h0, 32'h1);
    check_frame("brr0_a", mkpat(8'h96, 1'b0, 1'b0), 10, 0, t0);
    check_frame("brr0_b", mkpat(8'h3B, 1'b0, 1'b0), 10, 0, t1);
    tests++;
    if (t1 - t0 !== 11) begin fails++; $display("FAIL brr0_gap: got %0d expected 11", t1 - t0); end
  endtask

  task automatic test_midframe_reset();
    int t0 = 0;
    bit ok = 0;
    apb_write(4'h0, 32'h0);
    apb_write(4'hC, 32'd3);
    apb_write(4'h8, 32'hA5);
    apb_write(4'h8, 32'h3C);
    apb_write(4'h0, 32'h1);
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge PCLK); #1;
      if (tx === 1'b0) begin ok = 1; t0 = cyc; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_start: tx never went low"); end
    repeat (17) @(posedge PCLK);
    #1;
    tests++;
    if (tx !== 1'b0) begin fails++; $display("FAIL rst_bit3: got %b expected 0", tx); end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx: got %b expected 1", tx); end
    PRESET = 1'b1;
    chk_reg("rst_sr", 4'h4, 32'h2);
    chk_reg("rst_brr", 4'hC, 32'd867);
    apb_write(4'h0, 32'h1);
    check_idle("rst_no_frames", 60);
  endtask

  task automatic test_midframe_cfg();
    int t0;
    apb_write(4'h0, 32'h0);
    apb_write(4'hC, 32'd3);
    apb_write(4'h8, 32'h5A);
    apb_write(4'h8, 32'hC3);
    fork
      check_frame("cfg_old", mkpat(8'h5A, 1'b0, 1'b0), 10, 3, t0);
      begin
        apb_write(4'h0, 32'h1);
        repeat (4) @(posedge PCLK);
        apb_write(4'hC, 32'd1);
        apb_write(4'h0, 32'h0);
      end
    join
    check_idle("cfg_en_off", 60);
    chk_reg("cfg_sr_pending", 4'h4, 32'h0100);
    apb_write(4'h0, 32'h1);
    check_frame("cfg_new", mkpat(8'hC3, 1'b0, 1'b0), 10, 1, t0);
  endtask

  task automatic test_parity();
`ifdef UART_PARITY_EN
    int t0;
    apb_write(4'h0, 32'h7);
    chk_reg("cr_bits", 4'h0, 32'h7);
    apb_write(4'hC, 32'd0);
    apb_write(4'h0, 32'h3);
    apb_write(4'h8, 32'h07);
    check_frame("par_even", mkpat(8'h07, 1'b1, 1'b0), 11, 0, t0);
    apb_write(4'h0, 32'h7);
    apb_write(4'h8, 32'h07);
    check_frame("par_odd", mkpat(8'h07, 1'b1, 1'b1), 11, 0, t0);
`else
    apb_write(4'h0, 32'h7);
    chk_reg("cr_bits", 4'h0, 32'h1);
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_brr_zero();
    test_midframe_reset();
    test_midframe_cfg();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
